// File: rtl/jpeg_stream_sequencer.sv
// Byte-stream sequencer: feeds a JPEG image from synchronous byte memory to a decoder,
// zero-pads after the stream until the pixel target is met. Optional: JPEG_SEQ_TIMEOUT_EN.
module jpeg_stream_sequencer #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FLUSH_LIMIT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   stream_len,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              dec_ready,
    input  logic              start_scan,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic              pix_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       pix_count,
    output logic [31:0]       total_pix
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = 32;
`ifdef JPEG_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [7:0]        byte_out_q, byte_out_nxt;
    logic              byte_valid_q, byte_valid_nxt;
    logic              mem_rd_q, mem_rd_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              timeout_q, timeout_nxt;
    logic [31:0]       pix_q, pix_nxt;
    logic [31:0]       tot_q, tot_nxt;
    logic              known_q, known_nxt;
    logic [CNT_W-1:0]  fcnt_q, fcnt_nxt;
    logic              xfer, target_met, limit_hit, met_nxt, lim_nxt;

    assign xfer       = byte_valid_q & dec_ready;
    assign target_met = known_q && (pix_q >= tot_q);
    assign limit_hit  = TIMEOUT_EN && (fcnt_q >= CNT_W'(FLUSH_LIMIT));

    // Next-state and next-output logic; byte_valid is precomputed so FLUSH can exit with zero pad bytes.
    always_comb begin
        state_nxt    = state_q;
        addr_nxt     = addr_q;
        len_nxt      = len_q;
        byte_out_nxt = byte_out_q;
        done_nxt     = done_q;
        timeout_nxt  = timeout_q;
        pix_nxt      = pix_q;
        tot_nxt      = tot_q;
        known_nxt    = known_q;
        fcnt_nxt     = fcnt_q;

        if (busy_q) begin
            if (start_scan && !known_q) begin
                tot_nxt   = 32'(img_width) * 32'(img_height);
                known_nxt = 1'b1;
            end
            if (pix_valid && (pix_q != 32'hFFFF_FFFF)) begin
                pix_nxt = pix_q + 32'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_nxt     = stream_len;
                    addr_nxt    = '0;
                    pix_nxt     = '0;
                    tot_nxt     = '0;
                    known_nxt   = 1'b0;
                    fcnt_nxt    = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    state_nxt   = (stream_len != '0) ? S_FETCH : S_FLUSH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                byte_out_nxt = mem_rdata;
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    if (LEN_W'(addr_q) == (len_q - LEN_W'(1))) begin
                        state_nxt = S_FLUSH;
                    end else begin
                        addr_nxt  = addr_q + ADDR_W'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FLUSH: begin
                if (xfer && (fcnt_q != '1)) begin
                    fcnt_nxt = fcnt_q + CNT_W'(1);
                end
                if (target_met) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else if (limit_hit) begin
                    state_nxt   = S_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_FLUSH) begin
            byte_out_nxt = '0;
        end

        met_nxt        = known_nxt && (pix_nxt >= tot_nxt);
        lim_nxt        = TIMEOUT_EN && (fcnt_nxt >= CNT_W'(FLUSH_LIMIT));
        byte_valid_nxt = (state_nxt == S_SEND) ||
                         ((state_nxt == S_FLUSH) && !met_nxt && !lim_nxt);
        mem_rd_nxt     = (state_nxt == S_FETCH);
        busy_nxt       = (state_nxt == S_FETCH) || (state_nxt == S_LOAD) ||
                         (state_nxt == S_SEND)  || (state_nxt == S_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            pix_q        <= '0;
            tot_q        <= '0;
            known_q      <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_nxt;
            addr_q       <= addr_nxt;
            len_q        <= len_nxt;
            byte_out_q   <= byte_out_nxt;
            byte_valid_q <= byte_valid_nxt;
            mem_rd_q     <= mem_rd_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            timeout_q    <= timeout_nxt;
            pix_q        <= pix_nxt;
            tot_q        <= tot_nxt;
            known_q      <= known_nxt;
            fcnt_q       <= fcnt_nxt;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = addr_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign pix_count  = pix_q;
    assign total_pix  = tot_q;

endmodule

// File: tb/tb_jpeg_stream_sequencer.sv
// Scoreboard bench for jpeg_stream_sequencer: expected bytes queued at start, monitor pops on transfer.
module tb_jpeg_stream_sequencer;

    localparam int ADDR_W = 19;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int FL     = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   stream_len;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              dec_ready = 1'b0;
    logic              start_scan;
    logic [15:0]       img_width, img_height;
    logic              pix_valid;
    logic              busy, done, timeout;
    logic [31:0]       pix_count, total_pix;

    jpeg_stream_sequencer #(.ADDR_W(ADDR_W), .FLUSH_LIMIT(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stream_len(stream_len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .byte_out(byte_out), .byte_valid(byte_valid), .dec_ready(dec_ready),
        .start_scan(start_scan), .img_width(img_width), .img_height(img_height),
        .pix_valid(pix_valid), .busy(busy), .done(done), .timeout(timeout),
        .pix_count(pix_count), .total_pix(total_pix)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:255];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state shared by stimulus and monitor
    logic [7:0] exp_q [$];
    int  pad_cnt = 0;
    int  prev_data_edge = -1;
    int  last_data_edge = 0;
    bit  chk_spacing = 0;
    int  ready_mode = 1;     // 0 random, 1 always ready, 2 stall on 0xBB
    bit  pad_ready = 1;
    int  stall_left = 0;
    bit  stalling = 0;

    // Decoder readiness model
    always @(posedge clk) begin
        #1;
        stalling = 0;
        if (ready_mode == 1) begin
            dec_ready = 1'b1;
        end else if (ready_mode == 2) begin
            if (stall_left > 0 && (stall_left < 5 || (byte_valid && byte_out == 8'hBB))) begin
                dec_ready = 1'b0;
                stalling = 1;
                stall_left--;
            end else begin
                dec_ready = 1'b1;
            end
        end else if (exp_q.size() == 0 && !pad_ready) begin
            dec_ready = 1'b0;
        end else begin
            dec_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every transfer pops the next expected data byte, or must be a zero pad
    always @(negedge clk) begin
        if (stalling) begin
            check("hold_byte_out", 32'(byte_out), 32'h0000_00BB);
            check("hold_byte_valid", 32'(byte_valid), 32'd1);
        end
        if (byte_valid && dec_ready) begin
            if (exp_q.size() > 0) begin
                check("data_byte", 32'(byte_out), 32'(exp_q.pop_front()));
                if (chk_spacing && prev_data_edge >= 0)
                    check("byte_spacing", 32'(cyc + 1 - prev_data_edge), 32'd3);
                prev_data_edge = cyc + 1;
                last_data_edge = cyc + 1;
            end else begin
                check("pad_byte", 32'(byte_out), 32'd0);
                pad_cnt++;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_pix_count", pix_count, 32'd0);
        check("rst_total_pix", total_pix, 32'd0);
    endtask

    // One decode run: queue expectations, start, drive scan/pixels, wait for done, check results
    task automatic run(input int len, input int w, input int h, input bit do_scan,
                       input int scan_at, input bit dense, input bit inject, input bit exp_to);
        int p, rem, c, sc, n, finish_edge;
        bit sent, injected;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        pad_cnt = 0;
        prev_data_edge = -1;
        last_data_edge = 0;
        p = do_scan ? w * h : 0;
        stream_len = LEN_W'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (len == 0) begin
            check("len0_byte_valid", 32'(byte_valid), 32'd1);
            check("len0_byte_out", 32'(byte_out), 32'd0);
            check("len0_mem_rd", 32'(mem_rd), 32'd0);
        end else begin
            check("fetch_mem_rd", 32'(mem_rd), 32'd1);
            check("fetch_mem_addr", 32'(mem_addr), 32'd0);
        end
        rem = p;
        sent = !do_scan;
        sc = (scan_at >= 0) ? scan_at : $urandom_range(0, len * 3 + 4);
        c = 0;
        injected = 0;
        img_width = 16'(w);
        img_height = 16'(h);
        while (rem > 0 || !sent) begin
            start_scan = do_scan && (c == sc);
            if (start_scan) sent = 1;
            pix_valid = (rem > 0) && (dense || $urandom_range(0, 1) == 1);
            if (pix_valid) rem--;
            start = inject && !injected && busy && byte_valid && byte_out == 8'h00 && exp_q.size() == 0;
            if (start) begin injected = 1; stream_len = LEN_W'(5); end
            @(posedge clk); #1;
            c++;
        end
        finish_edge = cyc;
        start_scan = 1'b0;
        pix_valid = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            start = inject && !injected && busy && byte_valid && byte_out == 8'h00 && exp_q.size() == 0;
            if (start) begin injected = 1; stream_len = LEN_W'(5); end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_reached", 32'(done), 32'd1);
        check("final_pix_count", pix_count, 32'(p));
        check("final_total_pix", total_pix, 32'(p));
        check("final_timeout", 32'(timeout), 32'(exp_to));
        check("final_busy", 32'(busy), 32'd0);
        check("final_byte_valid", 32'(byte_valid), 32'd0);
        check("data_bytes_left", 32'(exp_q.size()), 32'd0);
        if (exp_to) check("timeout_pad_count", 32'(pad_cnt), 32'(FL));
        if (do_scan && len > 0 && finish_edge <= last_data_edge)
            check("no_pad_after_target", 32'(pad_cnt), 32'd0);
        if (inject) check("start_in_flush_issued", 32'(injected), 32'd1);
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        check("pix_ignored_in_done", pix_count, 32'(p));
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        stream_len = '0;
        start_scan = 1'b0;
        pix_valid = 1'b0;
        img_width = '0;
        img_height = '0;
`ifdef JPEG_SEQ_TIMEOUT_EN
        pad_ready = 0;
`else
        pad_ready = 1;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed four-byte stream at full decoder rate
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        ready_mode = 1;
        chk_spacing = 1;
        run(4, 1, 1, 1, 16, 1, 0, 0);
        chk_spacing = 0;

        // Decoder stalls five cycles on 0xBB
        ready_mode = 2;
        stall_left = 5;
        run(4, 0, 0, 1, 0, 1, 0, 0);
        check("stall_applied", 32'(stall_left), 32'd0);

        // 8x8 image, pixels trickling in mostly during flush
        ready_mode = 0;
        for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
        run(5, 8, 8, 1, 2, 0, 0, 0);

        // start pulsed during FLUSH must be ignored
        ready_mode = 1;
        run(3, 2, 2, 1, 14, 1, 1, 0);

        // Empty stream goes straight to FLUSH
        run(0, 0, 0, 1, 3, 1, 0, 0);

`ifdef JPEG_SEQ_TIMEOUT_EN
        run(2, 0, 0, 0, 0, 1, 0, 1);
`endif

        // Reset while byte 2 is held in SEND, then replay
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'h11 * (i + 1));
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(mem[i]);
        prev_data_edge = -1;
        stream_len = LEN_W'(6);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(byte_valid && byte_out == 8'h22) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_byte2_send", 32'(n < 100), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        check("transfers_before_reset", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(6, 1, 2, 1, 4, 1, 0, 0);

        // Randomized runs
        ready_mode = 0;
        repeat (10) begin
            int len;
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
            run(len, $urandom_range(0, 4), $urandom_range(0, 4), 1, -1, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jpeg_stream_sequencer.md
JPEG_STREAM_SEQUENCER -- requirements
Module: jpeg_stream_sequencer

Interface
REQ-001 Parameter ADDR_W, default 19: byte-memory address width (512 KiB image store).
REQ-002 Parameter FLUSH_LIMIT, default 50000: max zero-pad bytes after stream end.
REQ-003 Port clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  one-cycle pulse; begins a decode run.
REQ-006 Port stream_len  in  ADDR_W+1  number of JPEG bytes in memory; sampled on accepted start.
REQ-007 Port mem_rd  out  1  read strobe to synchronous byte memory.
REQ-008 Port mem_addr  out  ADDR_W  read address.
REQ-009 Port mem_rdata  in  8  read data, valid exactly one cycle after mem_rd.
REQ-010 Port byte_out  out  8  byte to decoder.
REQ-011 Port byte_valid  out  1  byte_out valid.
REQ-012 Port dec_ready  in  1  decoder accepts byte; transfer = byte_valid & dec_ready at a rising edge.
REQ-013 Port start_scan  in  1  decoder SOS pulse; img_width/img_height valid in that cycle.
REQ-014 Port img_width, img_height  in  16 each  image dimensions from decoder.
REQ-015 Port pix_valid  in  1  decoder pixel output strobe.
REQ-016 Port busy  out  1  run in progress.
REQ-017 Port done  out  1  run finished; held until next accepted start.
REQ-018 Port timeout  out  1  run ended by FLUSH_LIMIT; held with done.
REQ-019 Port pix_count, total_pix  out  32 each  pixels received / expected.

Function
REQ-020 States IDLE, FETCH, LOAD, SEND, FLUSH, DONE; busy SHALL be 1 exactly in FETCH, LOAD, SEND, FLUSH.
REQ-021 IDLE or DONE + start: latch stream_len, addr=0, clear pix_count, total_pix, total_known, flush_cnt, done, timeout; go FETCH if stream_len>0, else FLUSH.
REQ-022 start while busy SHALL be ignored.
REQ-023 FETCH: mem_rd=1 with mem_addr=addr for one cycle, then LOAD.
REQ-024 LOAD: capture mem_rdata into byte_out, assert byte_valid, go SEND.
REQ-025 SEND: hold byte_out/byte_valid stable until transfer; on transfer, if addr==stream_len-1 go FLUSH, else addr+1 and go FETCH (byte_valid drops for FETCH/LOAD).
REQ-026 FLUSH: byte_out=0x00, byte_valid=1; each transfer increments flush_cnt.
REQ-027 FLUSH exit to DONE when total_known & pix_count>=total_pix, checked every cycle including the entry cycle (zero pad bytes possible).
REQ-028 First start_scan of a run SHALL set total_pix=img_width*img_height (32-bit, full product) and total_known=1; later start_scan pulses in the same run ignored.
REQ-029 pix_valid SHALL increment pix_count in any busy state; saturate at 0xFFFFFFFF; ignored in IDLE/DONE.
REQ-030 start_scan and pix_valid in the same cycle: both take effect.
REQ-031 Pixel target reached before stream end: remaining bytes still sent; FLUSH then exits on entry.
REQ-032 Width or height 0: total_pix=0, FLUSH exits on entry.
REQ-033 DONE: byte_valid=0, mem_rd=0, done=1; outputs pix_count/total_pix hold final values.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, byte_out=0, byte_valid=0, mem_rd=0, mem_addr=0, busy=0, done=0, timeout=0, pix_count=0, total_pix=0, total_known=0, flush_cnt=0.
REQ-035 Reset mid-run SHALL abort with no further byte transfers; first post-release start behaves as from power-up.

Configuration
REQ-036 Macro JPEG_SEQ_TIMEOUT_EN defined: in FLUSH, when flush_cnt reaches FLUSH_LIMIT and pixel target not met, go DONE with timeout=1.
REQ-037 Macro undefined: no limit, flush_cnt may be omitted, FLUSH exits only per REQ-027, timeout tied to 0.

Verification
REQ-038 stream_len=4, memory AA BB CC DD, dec_ready=1 -> bytes AA,BB,CC,DD transferred, one per 3 cycles, then 0x00 pad.
REQ-039 dec_ready low 5 cycles while SEND holds 0xBB -> byte_out stays 0xBB, byte_valid stays 1, exactly one transfer of 0xBB.
REQ-040 start_scan with 8x8 during stream, 64 pix_valid pulses arriving during FLUSH -> DONE the cycle after pix_count reaches 64, total_pix=64, timeout=0.
REQ-041 JPEG_SEQ_TIMEOUT_EN, FLUSH_LIMIT=10, no start_scan -> exactly 10 pad bytes, done=1, timeout=1.
REQ-042 rst_n low during SEND of byte 2 -> byte_valid 0 immediately, all outputs at reset values; new start replays from addr 0.
REQ-043 start pulsed during FLUSH -> ignored, run completes unchanged; stream_len=0 start -> FLUSH directly.
